// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS core: opcodes, field ranges,
// fetch FSM states and the IF/ID bundle.
package cpu_pkg;

   localparam logic [5:0] OP_HALT = 6'b111111;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_JUMP = 6'b110010;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   typedef enum logic [1:0] {
      FS_RUN,
      FS_DRAIN,
      FS_HALTED
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   function automatic logic [5:0] instr_op(input logic [31:0] w);
      return w[OP_HI:OP_LO];
   endfunction

   function automatic logic [4:0] instr_rs(input logic [31:0] w);
      return w[RS_HI:RS_LO];
   endfunction

   function automatic logic [4:0] instr_rt(input logic [31:0] w);
      return w[RT_HI:RT_LO];
   endfunction

   function automatic logic [4:0] instr_rd(input logic [31:0] w);
      return w[RD_HI:RD_LO];
   endfunction

   function automatic logic [15:0] instr_imm(input logic [31:0] w);
      return w[IMM_HI:IMM_LO];
   endfunction

   function automatic logic is_halt(input logic [31:0] w);
      return instr_op(w) == OP_HALT;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load enable, bubble-insert flush, async reset.
// A flush only clears valid; pc/instr of a bubble are don't-care.
module if_id_reg
   import cpu_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   en_i,
   input  logic   flush_i,
   input  if_id_t d_i,
   output if_id_t q_o
);

   if_id_t q_q;

   // Flush beats load; otherwise capture when enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else if (flush_i) begin
         q_q.valid <= 1'b0;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, redirect/stall handling, halt drain FSM.
// Optional macro IF_TRACE_EN adds simulation-only fetch trace output.
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        halted
);

   localparam logic [3:0]  DRAIN_CNT = 4'(DRAIN_CYCLES);
   localparam logic [31:0] PC_RST    = RESET_PC & ~32'h3;

   fetch_state_e state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  redir_pc;

   logic   ld_en;
   logic   ld_flush;
   if_id_t ld_d;
   if_id_t ifid_q;

   assign redir_pc = redirect_pc & ~32'h3;

   // State, drain counter and PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FS_RUN;
         cnt_q   <= '0;
         pc_q    <= PC_RST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
      end
   end

   // Next state: redirect beats stall beats advance; HALTED is absorbing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      unique case (state_q)
         FS_RUN: begin
            if (redirect_valid) begin
               pc_d  = redir_pc;
               cnt_d = '0;
            end else if (!stall) begin
               if (is_halt(imem_instr)) begin
                  state_d = FS_DRAIN;
                  cnt_d   = DRAIN_CNT;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
            end
         end
         FS_DRAIN: begin
            if (redirect_valid) begin
               state_d = FS_RUN;
               cnt_d   = '0;
               pc_d    = redir_pc;
            end else if (!stall) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = FS_HALTED;
               end
            end
         end
         FS_HALTED: begin
            state_d = FS_HALTED;
         end
         default: begin
            state_d = FS_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // IF/ID control: capture in RUN, bubble on redirect or drain.
   always_comb begin
      ld_en    = 1'b0;
      ld_flush = 1'b0;
      ld_d     = '{valid: 1'b1, pc: pc_q, instr: imem_instr};
      unique case (1'b1)
         (state_q == FS_RUN): begin
            ld_flush = redirect_valid;
            ld_en    = !stall;
         end
         (state_q == FS_DRAIN): begin
            ld_flush = redirect_valid || !stall;
         end
         default: begin
            ld_en    = 1'b0;
            ld_flush = 1'b0;
         end
      endcase
   end

   if_id_reg u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (ld_en),
      .flush_i (ld_flush),
      .d_i     (ld_d),
      .q_o     (ifid_q)
   );

   assign imem_pc    = pc_q;
   assign ifid_valid = ifid_q.valid;
   assign ifid_pc    = ifid_q.pc;
   assign ifid_instr = ifid_q.instr;
   assign halted     = (state_q == FS_HALTED);

`ifdef IF_TRACE_EN
   // Simulation trace of captures and drain/halt transitions.
   always @(posedge clk) begin
      if (rst_n) begin
         if (ld_en && !ld_flush) begin
            $display("IF %h op=%h rs=%0d rt=%0d rd=%0d imm=%h",
                     pc_q, instr_op(imem_instr),
                     instr_rs(imem_instr), instr_rt(imem_instr),
                     instr_rd(imem_instr), instr_imm(imem_instr));
         end
         if (state_q != FS_DRAIN && state_d == FS_DRAIN) begin
            $display("IF drain start pc=%h", pc_q);
         end
         if (state_q != FS_HALTED && state_d == FS_HALTED) begin
            $display("IF halted pc=%h", pc_q);
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: scoreboard of expected IF/ID state per edge,
// checked 1 time unit after each rising edge.
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        halted;

   logic [31:0] mem [64];
   logic [5:0]  widx;

   int checks;
   int failures;

   typedef struct {
      string       tag;
      logic        v;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] ipc;
      logic        h;
   } exp_t;

   exp_t sbq[$];

   if_stage #(
      .RESET_PC     (32'h0000_0000),
      .DRAIN_CYCLES (3)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_pc        (imem_pc),
      .imem_instr     (imem_instr),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ifid_valid     (ifid_valid),
      .ifid_pc        (ifid_pc),
      .ifid_instr     (ifid_instr),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign widx       = imem_pc[7:2];
   assign imem_instr = mem[widx];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".valid"}, 32'(ifid_valid), 32'd0);
      chk({tag, ".pc"}, ifid_pc, 32'd0);
      chk({tag, ".instr"}, ifid_instr, 32'd0);
      chk({tag, ".halted"}, 32'(halted), 32'd0);
      chk({tag, ".imem_pc"}, imem_pc, 32'd0);
   endtask

   // Drive one edge's inputs, queue what IF/ID must hold after it, then
   // pop and compare. Bubble pc/instr are not compared.
   task automatic cyc(input string tag, input logic st, input logic rv,
                      input logic [31:0] rpc, input logic v,
                      input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] ipc, input logic h);
      exp_t e;
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      sbq.push_back('{tag: tag, v: v, pc: pc, instr: instr,
                      ipc: ipc, h: h});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk({e.tag, ".valid"}, 32'(ifid_valid), 32'(e.v));
      if (e.v) begin
         chk({e.tag, ".pc"}, ifid_pc, e.pc);
         chk({e.tag, ".instr"}, ifid_instr, e.instr);
      end
      chk({e.tag, ".imem_pc"}, imem_pc, e.ipc);
      chk({e.tag, ".halted"}, 32'(halted), 32'(e.h));
   endtask

   localparam logic [31:0] HLT = 32'hfc00_0000;

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | 32'(i);
      mem[0]  = 32'h0041_1800;
      mem[1]  = 32'h0a11_9000;
      mem[2]  = 32'h1061_1800;
      mem[3]  = 32'h48a6_3800;
      mem[4]  = HLT;
      mem[8]  = 32'h2222_0008;
      mem[16] = 32'h3333_0040;
      mem[17] = 32'h3333_0044;
      mem[63] = 32'h0bad_cafe;

      rst_n          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // The first edge after release may have been consumed above; re-sync.
      chk("first.pc", ifid_pc, 32'h0);
      chk("first.instr", ifid_instr, mem[0]);

      cyc("f1", 0, 0, 0, 1, 32'h4, mem[1], 32'h8, 0);
      cyc("st1", 1, 0, 0, 1, 32'h4, mem[1], 32'h8, 0);
      cyc("st2", 1, 0, 0, 1, 32'h4, mem[1], 32'h8, 0);
      cyc("f2", 0, 0, 0, 1, 32'h8, mem[2], 32'hc, 0);
      cyc("f3", 0, 0, 0, 1, 32'hc, mem[3], 32'h10, 0);

      cyc("rd1", 1, 1, 32'h23, 0, 0, 0, 32'h20, 0);
      cyc("rd2", 0, 0, 0, 1, 32'h20, mem[8], 32'h24, 0);

      cyc("h.rd", 0, 1, 32'h10, 0, 0, 0, 32'h10, 0);
      cyc("h.cap", 0, 0, 0, 1, 32'h10, HLT, 32'h10, 0);
      cyc("h.d1", 0, 0, 0, 0, 0, 0, 32'h10, 0);
      cyc("h.st", 1, 0, 0, 0, 0, 0, 32'h10, 0);
      cyc("h.d2", 0, 0, 0, 0, 0, 0, 32'h10, 0);
      cyc("h.d3", 0, 0, 0, 0, 0, 0, 32'h10, 1);
      cyc("h.ign1", 0, 1, 32'h40, 0, 0, 0, 32'h10, 1);
      cyc("h.ign2", 1, 0, 0, 0, 0, 0, 32'h10, 1);
      cyc("h.ign3", 0, 0, 0, 0, 0, 0, 32'h10, 1);

      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset("rst2");
      @(negedge clk);
      rst_n = 1'b1;
      cyc("r2.f0", 0, 0, 0, 1, 32'h0, mem[0], 32'h4, 0);

      cyc("c.rd", 0, 1, 32'h10, 0, 0, 0, 32'h10, 0);
      cyc("c.cap", 0, 0, 0, 1, 32'h10, HLT, 32'h10, 0);
      cyc("c.d1", 0, 0, 0, 0, 0, 0, 32'h10, 0);
      cyc("c.d2", 0, 1, 32'h40, 0, 0, 0, 32'h40, 0);
      cyc("c.tgt", 0, 0, 0, 1, 32'h40, mem[16], 32'h44, 0);

      cyc("l.rd", 0, 1, 32'h10, 0, 0, 0, 32'h10, 0);
      cyc("l.cap", 0, 0, 0, 1, 32'h10, HLT, 32'h10, 0);
      cyc("l.d1", 0, 0, 0, 0, 0, 0, 32'h10, 0);
      cyc("l.d2", 0, 0, 0, 0, 0, 0, 32'h10, 0);
      cyc("l.d3", 0, 1, 32'h44, 0, 0, 0, 32'h44, 0);
      cyc("l.tgt", 0, 0, 0, 1, 32'h44, mem[17], 32'h48, 0);

      cyc("m.rd", 0, 1, 32'h10, 0, 0, 0, 32'h10, 0);
      cyc("m.cap", 0, 0, 0, 1, 32'h10, HLT, 32'h10, 0);
      cyc("m.d1", 0, 0, 0, 0, 0, 0, 32'h10, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset("rst3");
      @(negedge clk);
      rst_n = 1'b1;
      cyc("r3.f0", 0, 0, 0, 1, 32'h0, mem[0], 32'h4, 0);

      cyc("w.rd", 0, 1, 32'hffff_fffc, 0, 0, 0, 32'hffff_fffc, 0);
      cyc("w.top", 0, 0, 0, 1, 32'hffff_fffc, mem[63], 32'h0, 0);
      cyc("w.zero", 0, 0, 0, 1, 32'h0, mem[0], 32'h4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter and drives it to the combinational instruction memory. It captures the returned word into the IF/ID pipeline register for decode. It also handles hazard stalls, branch/jump redirects from EX, and the drain-then-stop sequence after a `halt` (`32'hfc000000`) is fetched.

## Interface
- `RESET_PC`, `32'h0000_0000`: PC value loaded on reset.
- `DRAIN_CYCLES`, `3`: cycles after halt capture during which an older in-flight redirect may still cancel the halt. Legal range 1–15.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_pc`  out  32  byte address to instruction memory, which reads word `pc>>2` combinationally.
- `imem_instr`  in  32  instruction word for `imem_pc`, valid in the same cycle.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `redirect_valid`  in  1  EX: taken branch or jump.
- `redirect_pc`  in  32  target byte address.
- `ifid_valid`  out  1  IF/ID holds a real instruction; 0 means bubble.
- `ifid_pc`  out  32  PC of `ifid_instr`.
- `ifid_instr`  out  32  captured instruction.
- `halted`  out  1  core has stopped fetching; sticky until reset.

## Operation
- `imem_pc` = `pc_q`.
- `pc_q[1:0]` is always 0, and `redirect_pc[1:0]` is ignored (forced to 0).
- Per-edge priority: reset > redirect > stall > advance.
- FSM states:
  - `RUN`
  - `DRAIN`
  - `HALTED`
- RUN, advance:
  - IF/ID <= {1, `pc_q`, `imem_instr`}.
  - `pc_q` <= `pc_q`+4, modulo 2^32 (`32'hfffffffc` wraps to 0).
- RUN, stall: `pc_q` and IF/ID hold.
- Redirect, in RUN or DRAIN and regardless of `stall`:
  - `pc_q` <= `redirect_pc`.
  - `ifid_valid` <= 0 (wrong-path squash).
  - State goes to RUN; drain counter is cleared.
- RUN, advance with `imem_instr[31:26]`==`6'b111111`:
  - The halt is captured valid into IF/ID so decode sees it.
  - `pc_q` is NOT incremented.
  - State goes to DRAIN; counter is set to `DRAIN_CYCLES`.
- DRAIN:
  - Each unstalled edge: `ifid_valid` <= 0 and the counter decrements.
  - Stalled edges: IF/ID and counter hold.
  - When the counter decrements to 0: state goes to HALTED and `halted` <= 1.
- HALTED:
  - `pc_q` is frozen; `ifid_valid` = 0.
  - `stall` and `redirect_valid` are ignored.
  - Exit only via reset.
- Reset values, applied immediately on `rst_n` low:
  - `pc_q` = `RESET_PC`.
  - `ifid_valid` = 0, `ifid_pc` = 0, `ifid_instr` = 0.
  - `halted` = 0.
  - State RUN, counter 0.

## Timing
- Fetch to IF/ID: 1 edge.
- Redirect: edge 1 loads `pc_q` and bubbles IF/ID; edge 2 captures the target instruction. Penalty is 1 bubble from this stage.
- First edge after `rst_n` release captures the word at `RESET_PC`.
- Halt: captured on edge N; `halted` rises on edge N+`DRAIN_CYCLES`, plus any stalled edges.
- A redirect on the same edge the counter would reach 0 wins; `halted` stays 0.
- Stall and redirect on the same edge: redirect wins.
- No combinational path from inputs to outputs except `imem_instr`→(none) and `pc_q`→`imem_pc`.

## Configuration
- `IF_TRACE_EN` defined:
  - On every IF/ID capture, a simulation `$display` prints pc, opcode, rs, rt, rd and imm.
  - A `$display` is also printed on DRAIN entry and on HALTED entry.
- `IF_TRACE_EN` undefined: no display statements. The synthesizable logic is identical in both cases.

## Structure
- `cpu_pkg` holds:
  - opcode constants: `OP_HALT`=`6'b111111`, `OP_BEQ`=`6'b110000`, `OP_JUMP`=`6'b110010`;
  - instruction field bit ranges;
  - the fetch FSM state enum.
- Sub-module `if_id_reg` is the pipeline register, with enable (`!stall`), flush (bubble insert) and async reset. `if_stage` owns the PC, FSM and drain counter.

## Test plan
- Reset, then memory words 0..3 = `00411800`, `0a119000`, `10611800`, `48a63800` → on successive edges `ifid_pc` = 0, 4, 8, 12 with `ifid_valid`=1 and the matching instruction.
- `stall`=1 for 2 edges with `pc_q`=8 → `ifid_pc` stays 4 and `imem_pc` stays 8; fetch resumes at 8 afterwards.
- `redirect_valid`=1, `redirect_pc`=`32'h20`, with `stall`=1 → next edge: `imem_pc`=`32'h20`, `ifid_valid`=0; following edge: `ifid_pc`=`32'h20`, valid.
- `fc000000` at `32'h10` with no redirect → captured valid, then 3 bubbles; `halted`=1 exactly 3 edges after capture; `imem_pc` stays `32'h10` forever.
- Halt at `32'h10`, then redirect to `32'h40` on the 2nd DRAIN edge → state returns to RUN, `halted` never rises, `ifid_pc`=`32'h40` next edge.
- `rst_n` pulsed low mid-DRAIN, between edges → outputs go to reset values immediately; after release, fetch restarts at `RESET_PC`. Separately, `pc_q`=`32'hfffffffc` advances to 0.
